// File: rtl/sonic_meas_sched.sv
// Measurement scheduler for one ultrasonic ranger: triggers the sensor periodically or on
// demand, tracks its busy handshake, captures samples and keeps a running average.
module sonic_meas_sched #(
    parameter int PERIOD_CYC = 5_000_000,
    parameter int AVG_LOG2   = 2,
    parameter int ECHO_MAX   = 1_850_000,
    parameter int WDOG_CYC   = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        oneshot,
    output logic        sns_req,
    input  logic        sns_busy,
    input  logic [31:0] sns_data,
    output logic [31:0] dist_raw,
    output logic [31:0] dist_avg,
    output logic        avg_ready,
    output logic        dist_valid,
    output logic        out_of_range,
    output logic        overrun,
    output logic        wdog_err,
    output logic [15:0] meas_count
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam int WW    = $clog2(WDOG_CYC + 1);
    localparam int SW    = 32 + AVG_LOG2;
    localparam int PTRW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE,
        S_HOLDOFF
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     timer;
    logic              pending;
    logic [1:0]        retry_cnt;
    logic [1:0]        wait_cnt;
    logic [WW-1:0]     wdog_cnt;
    logic [31:0]       ring [DEPTH];
    logic [PTRW-1:0]   wr_ptr;
    logic [AVG_LOG2:0] fill;
    logic [SW-1:0]     sum;

    logic tick, trigger, wdog_set, in_range;

    assign tick      = enable && (timer == PW'(PERIOD_CYC - 1));
    assign trigger   = tick || oneshot;
    assign in_range  = sns_data < 32'(ECHO_MAX);
    assign sns_req   = (state == S_REQ);
    assign avg_ready = (fill == (AVG_LOG2 + 1)'(DEPTH));
    assign dist_avg  = sum[SW-1:AVG_LOG2];

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        wdog_set   = 1'b0;
        case (state)
            S_IDLE:      if (pending) state_next = S_REQ;
            S_REQ:       state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (sns_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (wait_cnt == 2'd3) begin
                    if (retry_cnt < 2'd3) begin
                        state_next = S_REQ;
                    end else begin
                        wdog_set   = 1'b1;
                        state_next = S_HOLDOFF;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!sns_busy) begin
                    state_next = S_CAPTURE;
                end else if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
                    wdog_set   = 1'b1;
                    state_next = S_HOLDOFF;
                end
            end
            S_CAPTURE:   state_next = S_HOLDOFF;
            S_HOLDOFF:   state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            wdog_err     <= 1'b0;
            retry_cnt    <= '0;
            wait_cnt     <= '0;
            wdog_cnt     <= '0;
            dist_raw     <= '0;
            out_of_range <= 1'b0;
            meas_count   <= '0;
            dist_valid   <= 1'b0;
            wr_ptr       <= '0;
            fill         <= '0;
            sum          <= '0;
            // NOTE: the ring is cleared on reset because the average is read before
            // the buffer has filled, so stale entries would show up in dist_avg.
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else begin
            state      <= state_next;
            dist_valid <= (state == S_CAPTURE);

            if (!enable || tick) timer <= '0;
            else                 timer <= timer + 1'b1;

            // A trigger is accepted only into an empty pending slot; the slot empties
            // when the scheduler launches the request.
            if (trigger && !pending)             pending <= 1'b1;
            else if (state == S_IDLE && pending) pending <= 1'b0;

            if (trigger && pending) overrun  <= 1'b1;
            if (wdog_set)           wdog_err <= 1'b1;

            if (state == S_IDLE)                     retry_cnt <= '0;
            else if (state == S_REQ)                 retry_cnt <= retry_cnt + 1'b1;
            else if (state == S_WAIT_BUSY && sns_busy) retry_cnt <= '0;

            wait_cnt <= (state == S_WAIT_BUSY) ? wait_cnt + 1'b1 : 2'd0;
            wdog_cnt <= (state == S_WAIT_DONE) ? wdog_cnt + 1'b1 : '0;

            if (state == S_CAPTURE) begin
                dist_raw     <= sns_data;
                out_of_range <= !in_range;
                meas_count   <= meas_count + 1'b1;
                if (in_range) begin
                    ring[wr_ptr] <= sns_data;
                    sum          <= sum - SW'(ring[wr_ptr]) + SW'(sns_data);
                    wr_ptr       <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                    if (!avg_ready) fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sonic_meas_sched.sv
// Directed bench for sonic_meas_sched with a behavioural ranger model that answers req
// with a programmable busy length and data word (or never answers).
module tb_sonic_meas_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        oneshot = 1'b0;
    logic        sns_req;
    logic        sns_busy;
    logic [31:0] sns_data;
    logic [31:0] dist_raw, dist_avg;
    logic        avg_ready, dist_valid, out_of_range, overrun, wdog_err;
    logic [15:0] meas_count;

    int n_vec = 0;
    int n_err = 0;

    // Sensor model controls
    int busy_len  = 20;
    int next_data = 0;
    bit sns_dead  = 1'b0;

    // Monitors
    int cyc = 0;
    int req_cnt = 0;
    int valid_cnt = 0;
    int req_t[$];

    sonic_meas_sched #(
        .PERIOD_CYC(100),
        .AVG_LOG2  (2),
        .ECHO_MAX  (1_850_000),
        .WDOG_CYC  (5000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .oneshot     (oneshot),
        .sns_req     (sns_req),
        .sns_busy    (sns_busy),
        .sns_data    (sns_data),
        .dist_raw    (dist_raw),
        .dist_avg    (dist_avg),
        .avg_ready   (avg_ready),
        .dist_valid  (dist_valid),
        .out_of_range(out_of_range),
        .overrun     (overrun),
        .wdog_err    (wdog_err),
        .meas_count  (meas_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sns_req) begin
            req_cnt++;
            req_t.push_back(cyc);
        end
        if (dist_valid) valid_cnt++;
    end

    // Ranger model: raises busy just after the edge that starts the req cycle, holds it for
    // busy_len cycles, then presents next_data as busy falls. Reset aborts a measurement.
    initial begin
        sns_busy = 1'b0;
        sns_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                sns_busy = 1'b0;
                sns_data = '0;
            end else if (sns_req && !sns_dead) begin
                sns_busy = 1'b1;
                for (int i = 0; i < busy_len && !rst; i++) begin
                    @(posedge clk); #1;
                end
                sns_busy = 1'b0;
                if (!rst) sns_data = next_data;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; oneshot = 1'b0; sns_dead = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_cnt = 0; valid_cnt = 0; req_t.delete();
    endtask

    task automatic pulse_oneshot();
        oneshot = 1'b1;
        @(negedge clk);
        oneshot = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (dist_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_busy(input bit level, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sns_busy == level) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [102:0] got;
        repeat (3) @(negedge clk);
        got = {sns_req, dist_raw, dist_avg, avg_ready, dist_valid, out_of_range,
               overrun, wdog_err, meas_count};
        n_vec++;
        if (got !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", got);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        busy_len = 1000; next_data = 1000;
        pulse_oneshot();
        n_vec++;
        if (sns_req !== 1'b0) begin n_err++; $display("FAIL req_early: got %b expected 0", sns_req); end
        @(negedge clk);
        n_vec++;
        if (sns_req !== 1'b1) begin n_err++; $display("FAIL req_latency: got %b expected 1", sns_req); end
        wait_busy(1'b1, 10, ok);
        wait_busy(1'b0, 1100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL busy_fall_timeout: got 0 expected 1"); end
        @(negedge clk);
        n_vec++;
        if (dist_valid !== 1'b0) begin n_err++; $display("FAIL valid_early: got %b expected 0", dist_valid); end
        @(negedge clk);
        n_vec++;
        if (dist_valid !== 1'b1) begin n_err++; $display("FAIL valid_latency: got %b expected 1", dist_valid); end
        n_vec++;
        if (dist_raw !== 32'd1000) begin n_err++; $display("FAIL single_raw: got %0d expected 1000", dist_raw); end
        n_vec++;
        if (dist_avg !== 32'd250) begin n_err++; $display("FAIL single_avg: got %0d expected 250", dist_avg); end
        n_vec++;
        if (meas_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", meas_count); end
        repeat (5) @(negedge clk);
        n_vec++;
        if (req_cnt !== 1) begin n_err++; $display("FAIL single_reqs: got %0d expected 1", req_cnt); end
    endtask

    task automatic test_average();
        int d[5]     = '{100, 200, 300, 400, 500};
        int a[5]     = '{25, 75, 150, 250, 350};
        bit ok;
        do_reset();
        busy_len = 20; next_data = d[0];
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(300, ok);
            n_vec++;
            if (!ok) begin n_err++; $display("FAIL avg_timeout[%0d]: got 0 expected 1", i); end
            n_vec++;
            if (dist_raw !== 32'(d[i])) begin
                n_err++; $display("FAIL avg_raw[%0d]: got %0d expected %0d", i, dist_raw, d[i]);
            end
            n_vec++;
            if (dist_avg !== 32'(a[i])) begin
                n_err++; $display("FAIL avg_value[%0d]: got %0d expected %0d", i, dist_avg, a[i]);
            end
            n_vec++;
            if (avg_ready !== (i >= 3)) begin
                n_err++; $display("FAIL avg_ready[%0d]: got %b expected %b", i, avg_ready, (i >= 3));
            end
            if (i < 4) next_data = d[i+1];
        end
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL avg_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        next_data = 1_850_000;
        wait_valid(300, ok);
        n_vec++;
        if (!ok || out_of_range !== 1'b1) begin
            n_err++; $display("FAIL oor_flag: got %b expected 1", out_of_range);
        end
        n_vec++;
        if (dist_raw !== 32'd1_850_000) begin n_err++; $display("FAIL oor_raw: got %0d expected 1850000", dist_raw); end
        n_vec++;
        if (dist_avg !== 32'd350) begin n_err++; $display("FAIL oor_avg_hold: got %0d expected 350", dist_avg); end
        n_vec++;
        if (meas_count !== 16'd6) begin n_err++; $display("FAIL oor_count: got %0d expected 6", meas_count); end
        next_data = 1_849_999;
        wait_valid(300, ok);
        enable = 1'b0;
        n_vec++;
        if (!ok || out_of_range !== 1'b0) begin
            n_err++; $display("FAIL edge_flag: got %b expected 0", out_of_range);
        end
        n_vec++;
        if (dist_avg !== 32'd462_799) begin n_err++; $display("FAIL edge_avg: got %0d expected 462799", dist_avg); end
        n_vec++;
        if (meas_count !== 16'd7) begin n_err++; $display("FAIL edge_count: got %0d expected 7", meas_count); end
    endtask

    task automatic test_no_busy();
        bit ok;
        do_reset();
        sns_dead = 1'b1;
        pulse_oneshot();
        repeat (60) @(negedge clk);
        n_vec++;
        if (req_cnt !== 3) begin n_err++; $display("FAIL nobusy_reqs: got %0d expected 3", req_cnt); end
        if (req_t.size() == 3) begin
            n_vec++;
            if (req_t[1] - req_t[0] != 5 || req_t[2] - req_t[1] != 5) begin
                n_err++; $display("FAIL nobusy_spacing: got %0d,%0d expected 5,5",
                                  req_t[1] - req_t[0], req_t[2] - req_t[1]);
            end
        end
        n_vec++;
        if (wdog_err !== 1'b1) begin n_err++; $display("FAIL nobusy_wdog: got %b expected 1", wdog_err); end
        // A working sensor now must be served, showing the scheduler returned to idle.
        sns_dead = 1'b0; busy_len = 10; next_data = 4242;
        pulse_oneshot();
        wait_valid(100, ok);
        n_vec++;
        if (!ok || dist_raw !== 32'd4242) begin
            n_err++; $display("FAIL nobusy_recover: got %0d expected 4242", dist_raw);
        end
        n_vec++;
        if (wdog_err !== 1'b1) begin n_err++; $display("FAIL wdog_sticky: got %b expected 1", wdog_err); end
    endtask

    task automatic test_busy_stuck();
        bit ok;
        do_reset();
        busy_len = 6000; next_data = 99;
        pulse_oneshot();
        wait_busy(1'b1, 10, ok);
        repeat (4990) @(negedge clk);
        n_vec++;
        if (wdog_err !== 1'b0) begin n_err++; $display("FAIL stuck_early: got %b expected 0", wdog_err); end
        repeat (20) @(negedge clk);
        n_vec++;
        if (wdog_err !== 1'b1) begin n_err++; $display("FAIL stuck_wdog: got %b expected 1", wdog_err); end
        wait_busy(1'b0, 1200, ok);
        repeat (10) @(negedge clk);
        n_vec++;
        if (valid_cnt !== 0 || meas_count !== 16'd0) begin
            n_err++; $display("FAIL stuck_no_valid: got %0d/%0d expected 0/0", valid_cnt, meas_count);
        end
    endtask

    task automatic test_coincident();
        bit ok;
        do_reset();
        busy_len = 20; next_data = 55;
        enable = 1'b1;
        repeat (99) @(negedge clk);
        pulse_oneshot();
        wait_valid(100, ok);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (!ok || overrun !== 1'b0) begin
            n_err++; $display("FAIL coincident_overrun: got %b expected 0", overrun);
        end
        n_vec++;
        if (req_cnt !== 1 || meas_count !== 16'd1) begin
            n_err++; $display("FAIL coincident_single: got %0d/%0d expected 1/1", req_cnt, meas_count);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        busy_len = 300; next_data = 777;
        enable = 1'b1;
        repeat (250) @(negedge clk);
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b expected 0", overrun); end
        wait_valid(400, ok);
        enable = 1'b0;
        n_vec++;
        if (!ok || overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        n_vec++;
        if (meas_count !== 16'd1) begin n_err++; $display("FAIL overrun_count1: got %0d expected 1", meas_count); end
        wait_valid(500, ok);
        n_vec++;
        if (!ok || meas_count !== 16'd2) begin
            n_err++; $display("FAIL pending_served: got %0d expected 2", meas_count);
        end
        repeat (600) @(negedge clk);
        n_vec++;
        if (meas_count !== 16'd2 || req_cnt !== 2) begin
            n_err++; $display("FAIL overrun_quiet: got %0d/%0d expected 2/2", meas_count, req_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        busy_len = 200;
        pulse_oneshot();
        wait_busy(1'b1, 10, ok);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (overrun !== 1'b0 || meas_count !== 16'd0 || dist_raw !== 32'd0 || dist_avg !== 32'd0) begin
            n_err++; $display("FAIL reset_mid: got ovr=%b cnt=%0d raw=%0d avg=%0d expected all 0",
                              overrun, meas_count, dist_raw, dist_avg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_average();
        test_out_of_range();
        test_no_busy();
        test_busy_stuck();
        test_coincident();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
